dcache_assoc: RTL and testbench

DCACHE_ASSOC -- requirements
Module: dcache_assoc

---
 rtl/dcache_assoc.sv | 170 +++++++++++++++++
 tb/tb_dcache_assoc.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_assoc.sv
// dcache_assoc: 2-way set-associative, write-back, write-allocate byte cache
// sitting between a CPU byte port and a block-wide memory port.
module dcache_assoc #(
  parameter int ADDR_W      = 8,
  parameter int INDEX_BITS  = 2,
  parameter int OFFSET_BITS = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              read,
  input  logic                              write,
  input  logic [ADDR_W-1:0]                 address,
  input  logic [7:0]                        writedata,
  output logic [7:0]                        readdata,
  output logic                              busywait,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [ADDR_W-OFFSET_BITS-1:0]     mem_address,
  output logic [8*(2**OFFSET_BITS)-1:0]     mem_writedata,
  input  logic [8*(2**OFFSET_BITS)-1:0]     mem_readdata,
  input  logic                              mem_busywait
);

  localparam int SETS    = 2**INDEX_BITS;
  localparam int BLOCK_W = 8*(2**OFFSET_BITS);
  localparam int TAG_W   = ADDR_W - INDEX_BITS - OFFSET_BITS;

  if (ADDR_W <= INDEX_BITS + OFFSET_BITS) begin : g_param_check
    $error("dcache_assoc: ADDR_W must exceed INDEX_BITS+OFFSET_BITS");
  end

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, FILL} state_t;

  state_t state, next_state;

  // Address fields of the current CPU request
  logic [TAG_W-1:0]       tag;
  logic [INDEX_BITS-1:0]  index;
  logic [OFFSET_BITS-1:0] offset;

  assign tag    = address[ADDR_W-1 -: TAG_W];
  assign index  = address[OFFSET_BITS +: INDEX_BITS];
  assign offset = address[OFFSET_BITS-1:0];

  // Storage: data/tag arrays are never reset, status bits are
  logic [BLOCK_W-1:0]      data_arr [2][SETS];
  logic [TAG_W-1:0]        tag_arr  [2][SETS];
  logic [SETS-1:0][1:0]    valid;
  logic [SETS-1:0][1:0]    dirty;
  logic [SETS-1:0]         lru;

  // Miss context held stable from detection through FILL
  logic                    vic_way;
  logic [TAG_W-1:0]        lat_tag;
  logic [INDEX_BITS-1:0]   lat_index;
  logic [TAG_W-1:0]        vic_tag;
  logic [BLOCK_W-1:0]      fill_block;

  logic hit0, hit1, hit, hit_way;
  logic req, is_write;
  logic vic_sel, vic_dirty;
  logic [BLOCK_W-1:0] hit_block;

  assign req      = read | write;
  // A simultaneous read and write is served as a plain read
  assign is_write = write & ~read;

  assign hit0    = valid[index][0] && (tag_arr[0][index] == tag);
  assign hit1    = valid[index][1] && (tag_arr[1][index] == tag);
  assign hit     = hit0 | hit1;
  assign hit_way = hit1;

  assign hit_block = data_arr[hit_way][index];
  assign readdata  = hit_block[{offset, 3'b000} +: 8];

  // Fill an empty way first (way0 before way1), otherwise replace the LRU way
  assign vic_sel   = !valid[index][0] ? 1'b0 :
                     !valid[index][1] ? 1'b1 : lru[index];
  assign vic_dirty = valid[index][vic_sel] & dirty[index][vic_sel];

  // Next-state and memory/CPU handshake outputs
  always_comb begin
    next_state    = state;
    busywait      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = {lat_tag, lat_index};
    mem_writedata = data_arr[vic_way][lat_index];
    case (state)
      IDLE: begin
        busywait = reset & req & ~hit;
        if (req && !hit) begin
          next_state = vic_dirty ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        mem_write   = 1'b1;
        mem_address = {vic_tag, lat_index};
        busywait    = 1'b1;
        if (!mem_busywait) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        mem_read = 1'b1;
        busywait = 1'b1;
        if (!mem_busywait) begin
          next_state = FILL;
        end
      end
      FILL: begin
        busywait   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, status bits and latched miss context
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      lru       <= '0;
      vic_way   <= 1'b0;
      lat_tag   <= '0;
      lat_index <= '0;
      vic_tag   <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (req && hit) begin
            lru[index] <= ~hit_way;
            if (is_write) begin
              dirty[index][hit_way] <= 1'b1;
            end
          end else if (req) begin
            vic_way   <= vic_sel;
            lat_tag   <= tag;
            lat_index <= index;
            vic_tag   <= tag_arr[vic_sel][index];
          end
        end
        FILL: begin
          valid[lat_index][vic_way] <= 1'b1;
          dirty[lat_index][vic_way] <= 1'b0;
          lru[lat_index]            <= ~vic_way;
        end
        default: ;
      endcase
    end
  end

  // Data and tag array updates: write-hit byte merge, block capture and fill
  always_ff @(posedge clk) begin
    if (state == IDLE && req && hit && is_write) begin
      data_arr[hit_way][index][{offset, 3'b000} +: 8] <= writedata;
    end
    if (state == FETCH && !mem_busywait) begin
      fill_block <= mem_readdata;
    end
    if (state == FILL) begin
      data_arr[vic_way][lat_index] <= fill_block;
      tag_arr[vic_way][lat_index]  <= lat_tag;
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Self-checking bench for dcache_assoc with a behavioral block memory.
module tb_dcache_assoc;

  logic        clk;
  logic        reset;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } txn_t;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wd;
    int         busy;
    logic [7:0] data;
    logic       chk;
  } step_t;

  txn_t       mem_q [$];
  logic [7:0] rd_q  [$];

  logic [31:0] mem [64];
  logic [3:0]  cnt;

  dcache_assoc dut (
    .clk          (clk),
    .reset        (reset),
    .read         (read),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input logic [5:0] b);
    return 32'h44332211 ^ {4{2'b00, b}};
  endfunction

  // Memory: each transaction stalls for two cycles and completes on the third
  assign mem_busywait = (mem_read || mem_write) && (cnt < 4'd2);
  assign mem_readdata = mem[mem_address];

  // Memory model plus monitor comparing completed transactions with the queue
  initial begin : mem_model
    logic done, req_s;
    txn_t cur, exp_t;
    for (int i = 0; i < 64; i++) mem[i] <= pattern(i[5:0]);
    cnt <= 4'd0;
    forever begin
      @(negedge clk);
      req_s = mem_read || mem_write;
      done  = reset && req_s && !mem_busywait;
      cur.wr   = mem_write;
      cur.addr = mem_address;
      cur.data = mem_writedata;
      if (done) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected: wr=%0b addr=%h data=%h, required no transaction",
                   cur.wr, cur.addr, cur.data);
        end else begin
          exp_t = mem_q.pop_front();
          if (cur.wr !== exp_t.wr || cur.addr !== exp_t.addr ||
              (exp_t.wr && cur.data !== exp_t.data)) begin
            errors++;
            $display("FAIL mem_txn: got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                     cur.wr, cur.addr, cur.data, exp_t.wr, exp_t.addr, exp_t.data);
          end
        end
      end
      @(posedge clk);
      if (!req_s || done) cnt <= 4'd0;
      else                cnt <= cnt + 4'd1;
      if (done && cur.wr) mem[cur.addr] <= cur.data;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic do_access(input logic rd, input logic wr, input logic [7:0] addr,
                           input logic [7:0] wd, output int busy, output logic [7:0] rdv);
    @(posedge clk);
    #1;
    read      = rd;
    write     = wr;
    address   = addr;
    writedata = wd;
    busy      = 0;
    @(negedge clk);
    while (busywait === 1'b1 && busy < 50) begin
      busy++;
      @(negedge clk);
    end
    rdv = readdata;
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    read      = 1'b1;
    write     = 1'b0;
    address   = 8'h00;
    writedata = 8'h00;
    #3;
    checks++;
    if (busywait !== 1'b0) begin
      errors++; $display("FAIL reset_busywait: got %b, required 0", busywait);
    end
    checks++;
    if (mem_read !== 1'b0) begin
      errors++; $display("FAIL reset_mem_read: got %b, required 0", mem_read);
    end
    checks++;
    if (mem_write !== 1'b0) begin
      errors++; $display("FAIL reset_mem_write: got %b, required 0", mem_write);
    end
    read = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_read_miss();
    step_t s [1];
    int busy; logic [7:0] rdv, exp;
    s = '{'{1'b1, 1'b0, 8'h00, 8'h00, 5, 8'h11, 1'b1}};
    mem_q.push_back('{1'b0, 6'h00, 32'h0});
    foreach (s[i]) begin
      if (s[i].chk) rd_q.push_back(s[i].data);
      do_access(s[i].rd, s[i].wr, s[i].addr, s[i].wd, busy, rdv);
      checks++;
      if (busy !== s[i].busy) begin
        errors++; $display("FAIL read_miss_busy[%0d]: got %0d cycles, required %0d", i, busy, s[i].busy);
      end
      if (s[i].chk) begin
        exp = rd_q.pop_front(); checks++;
        if (rdv !== exp) begin
          errors++; $display("FAIL read_miss_data[%0d]: got %h, required %h", i, rdv, exp);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_read_hit_and_both();
    step_t s [3];
    int busy; logic [7:0] rdv, exp;
    s = '{'{1'b1, 1'b0, 8'h01, 8'h00, 0, 8'h22, 1'b1},
          '{1'b1, 1'b1, 8'h01, 8'h55, 0, 8'h22, 1'b1},
          '{1'b1, 1'b0, 8'h01, 8'h00, 0, 8'h22, 1'b1}};
    foreach (s[i]) begin
      if (s[i].chk) rd_q.push_back(s[i].data);
      do_access(s[i].rd, s[i].wr, s[i].addr, s[i].wd, busy, rdv);
      checks++;
      if (busy !== s[i].busy) begin
        errors++; $display("FAIL hit_busy[%0d]: got %0d cycles, required %0d", i, busy, s[i].busy);
      end
      if (s[i].chk) begin
        exp = rd_q.pop_front(); checks++;
        if (rdv !== exp) begin
          errors++; $display("FAIL hit_data[%0d]: got %h, required %h", i, rdv, exp);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_writeback_evict();
    step_t s [4];
    int busy; logic [7:0] rdv, exp;
    s = '{'{1'b0, 1'b1, 8'h00, 8'hAA, 0, 8'h00, 1'b0},
          '{1'b1, 1'b0, 8'h00, 8'h00, 0, 8'hAA, 1'b1},
          '{1'b1, 1'b0, 8'h10, 8'h00, 5, 8'h15, 1'b1},
          '{1'b1, 1'b0, 8'h20, 8'h00, 8, 8'h19, 1'b1}};
    mem_q.push_back('{1'b0, 6'h04, 32'h0});
    mem_q.push_back('{1'b1, 6'h00, 32'h443322AA});
    mem_q.push_back('{1'b0, 6'h08, 32'h0});
    foreach (s[i]) begin
      if (s[i].chk) rd_q.push_back(s[i].data);
      do_access(s[i].rd, s[i].wr, s[i].addr, s[i].wd, busy, rdv);
      checks++;
      if (busy !== s[i].busy) begin
        errors++; $display("FAIL wb_busy[%0d]: got %0d cycles, required %0d", i, busy, s[i].busy);
      end
      if (s[i].chk) begin
        exp = rd_q.pop_front(); checks++;
        if (rdv !== exp) begin
          errors++; $display("FAIL wb_data[%0d]: got %h, required %h", i, rdv, exp);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_lru_replace();
    step_t s [4];
    int busy; logic [7:0] rdv, exp;
    s = '{'{1'b1, 1'b0, 8'h10, 8'h00, 0, 8'h15, 1'b1},
          '{1'b1, 1'b0, 8'h00, 8'h00, 5, 8'hAA, 1'b1},
          '{1'b1, 1'b0, 8'h20, 8'h00, 5, 8'h19, 1'b1},
          '{1'b1, 1'b0, 8'h00, 8'h00, 0, 8'hAA, 1'b1}};
    mem_q.push_back('{1'b0, 6'h00, 32'h0});
    mem_q.push_back('{1'b0, 6'h08, 32'h0});
    foreach (s[i]) begin
      if (s[i].chk) rd_q.push_back(s[i].data);
      do_access(s[i].rd, s[i].wr, s[i].addr, s[i].wd, busy, rdv);
      checks++;
      if (busy !== s[i].busy) begin
        errors++; $display("FAIL lru_busy[%0d]: got %0d cycles, required %0d", i, busy, s[i].busy);
      end
      if (s[i].chk) begin
        exp = rd_q.pop_front(); checks++;
        if (rdv !== exp) begin
          errors++; $display("FAIL lru_data[%0d]: got %h, required %h", i, rdv, exp);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    step_t s [4];
    int busy; logic [7:0] rdv, exp;
    s = '{'{1'b1, 1'b0, 8'h37, 8'h00, 5, 8'h49, 1'b1},
          '{1'b0, 1'b1, 8'h36, 8'h77, 0, 8'h00, 1'b0},
          '{1'b1, 1'b0, 8'h36, 8'h00, 0, 8'h77, 1'b1},
          '{1'b1, 1'b0, 8'h35, 8'h00, 0, 8'h2F, 1'b1}};
    mem_q.push_back('{1'b0, 6'h0D, 32'h0});
    foreach (s[i]) begin
      if (s[i].chk) rd_q.push_back(s[i].data);
      do_access(s[i].rd, s[i].wr, s[i].addr, s[i].wd, busy, rdv);
      checks++;
      if (busy !== s[i].busy) begin
        errors++; $display("FAIL b2b_busy[%0d]: got %0d cycles, required %0d", i, busy, s[i].busy);
      end
      if (s[i].chk) begin
        exp = rd_q.pop_front(); checks++;
        if (rdv !== exp) begin
          errors++; $display("FAIL b2b_data[%0d]: got %h, required %h", i, rdv, exp);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_reset_fetch();
    int n; int busy; logic [7:0] rdv, exp;
    @(posedge clk);
    #1;
    read    = 1'b1;
    write   = 1'b0;
    address = 8'h28;
    n = 0;
    @(negedge clk);
    while (mem_read !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (mem_read !== 1'b1) begin
      errors++; $display("FAIL rst_fetch_reached: mem_read %b, required 1", mem_read);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0) begin
      errors++; $display("FAIL rst_fetch_mem_read: got %b, required 0", mem_read);
    end
    checks++;
    if (busywait !== 1'b0) begin
      errors++; $display("FAIL rst_fetch_busywait: got %b, required 0", busywait);
    end
    read = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mem_q.push_back('{1'b0, 6'h00, 32'h0});
    rd_q.push_back(8'hAA);
    do_access(1'b1, 1'b0, 8'h00, 8'h00, busy, rdv);
    checks++;
    if (busy !== 5) begin
      errors++; $display("FAIL rst_refetch_busy: got %0d cycles, required 5", busy);
    end
    exp = rd_q.pop_front(); checks++;
    if (rdv !== exp) begin
      errors++; $display("FAIL rst_refetch_data: got %h, required %h", rdv, exp);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit_and_both();
    test_writeback_evict();
    test_lru_replace();
    test_back_to_back();
    test_reset_fetch();
    repeat (3) @(negedge clk);
    checks++;
    if (mem_q.size() != 0) begin
      errors++; $display("FAIL mem_pending: %0d transactions outstanding, required 0", mem_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
